ram_port_arbiter: RTL

- Two-requester controller for the shared single-port RAM (cache_altera interface: i_request/i_write/i_address/i_data in, o_data/o_data_DV out).
- Arbitrates port A (instruction fetch) and port B (data) and sequences one RAM access at a time.
- Optionally zero-fills the whole RAM after reset.
- Returns read data, or the write echo, to the port that owns the access.

---
 rtl/ram_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port RAM between an instruction-fetch port (A) and a
// data port (B). One RAM access is in flight at a time. After reset the
// controller can optionally zero-fill the whole RAM before it serves either
// port. Read data, or the RAM's echo of a write, goes back to the port that
// owns the access.

module ram_port_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int CLEAR_ON_RESET = 1,
    parameter int ARB_MODE       = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    input  logic                  i_pa_req,
    input  logic                  i_pa_write,
    input  logic [ADDR_WIDTH-1:0] i_pa_addr,
    input  logic [DATA_WIDTH-1:0] i_pa_wdata,
    output logic                  o_pa_ack,
    output logic [DATA_WIDTH-1:0] o_pa_rdata,
    output logic                  o_pa_rvalid,

    input  logic                  i_pb_req,
    input  logic                  i_pb_write,
    input  logic [ADDR_WIDTH-1:0] i_pb_addr,
    input  logic [DATA_WIDTH-1:0] i_pb_wdata,
    output logic                  o_pb_ack,
    output logic [DATA_WIDTH-1:0] o_pb_rdata,
    output logic                  o_pb_rvalid,

    output logic                  o_ram_request,
    output logic                  o_ram_write,
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    input  logic [DATA_WIDTH-1:0] i_ram_data,
    input  logic                  i_ram_data_DV,

    output logic                  o_init_done
);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clear_addr;
    logic                    last_grant_b;
    logic                    owner_b;
    logic                    grant_a;
    logic                    grant_b;

    // Pick the winner for this cycle; only acted on while idle.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (ARB_MODE != 0) begin
            grant_a = i_pa_req;
        end else begin
            grant_a = i_pa_req && (!i_pb_req || last_grant_b);
        end
        grant_b = i_pb_req && !grant_a;
    end

    // Main sequencer: clear sweep, arbitration, command issue and data return.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clear_addr    <= '0;
            last_grant_b  <= 1'b1;
            owner_b       <= 1'b0;
            o_pa_ack      <= 1'b0;
            o_pb_ack      <= 1'b0;
            o_pa_rdata    <= '0;
            o_pb_rdata    <= '0;
            o_pa_rvalid   <= 1'b0;
            o_pb_rvalid   <= 1'b0;
            o_ram_request <= 1'b0;
            o_ram_write   <= 1'b0;
            o_ram_address <= '0;
            o_ram_data    <= '0;
            o_init_done   <= 1'b0;
        end else begin
            o_pa_ack    <= 1'b0;
            o_pb_ack    <= 1'b0;
            o_pa_rvalid <= 1'b0;
            o_pb_rvalid <= 1'b0;

            case (state)
                ST_CLEAR: begin
                    o_ram_request <= 1'b1;
                    o_ram_write   <= 1'b1;
                    o_ram_data    <= '0;
                    o_ram_address <= clear_addr;
                    clear_addr    <= clear_addr + 1'b1;
                    if (clear_addr == LAST_ADDR) begin
                        state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    o_init_done   <= 1'b1;
                    o_ram_request <= 1'b0;
                    if (grant_a) begin
                        o_ram_request <= 1'b1;
                        o_ram_write   <= i_pa_write;
                        o_ram_address <= i_pa_addr;
                        o_ram_data    <= i_pa_wdata;
                        o_pa_ack      <= 1'b1;
                        last_grant_b  <= 1'b0;
                        owner_b       <= 1'b0;
                        state         <= ST_ISSUE;
                    end else if (grant_b) begin
                        o_ram_request <= 1'b1;
                        o_ram_write   <= i_pb_write;
                        o_ram_address <= i_pb_addr;
                        o_ram_data    <= i_pb_wdata;
                        o_pb_ack      <= 1'b1;
                        last_grant_b  <= 1'b1;
                        owner_b       <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    o_ram_request <= 1'b0;
                    state         <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (i_ram_data_DV) begin
                        if (owner_b) begin
                            o_pb_rdata  <= i_ram_data;
                            o_pb_rvalid <= 1'b1;
                        end else begin
                            o_pa_rdata  <= i_ram_data;
                            o_pa_rvalid <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
